// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: multi-lane circular instruction queue between fetch and decode, one-cycle flush
module fetch_inst_queue #(
  parameter int ENTRY_W   = 64,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 2,
  parameter int DEPTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [IN_LANES-1:0]              pre_to_now_valid_i,
  input  logic [IN_LANES*ENTRY_W-1:0]      pre_to_ibus,
  output logic                             now_allowin_o,
  output logic [OUT_LANES-1:0]             now_to_next_valid_o,
  output logic [OUT_LANES*ENTRY_W-1:0]     to_next_obus,
  input  logic [$clog2(OUT_LANES+1)-1:0]   next_accept_i,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [CW-1:0] count, push_n, pop_n, avail, accept;
  logic [PW-1:0] off [IN_LANES];
  logic push;
  assign now_allowin_o = count <= CW'(DEPTH - IN_LANES);
  assign push = now_allowin_o && |pre_to_now_valid_i && !flush_i && !rst;
  assign accept = CW'(next_accept_i);
  assign avail = count < CW'(OUT_LANES) ? count : CW'(OUT_LANES);
  assign pop_n = accept < avail ? accept : avail;
  assign count_o = count;
  always_comb begin
    push_n = '0;
    for (int k = 0; k < IN_LANES; k++) begin
      off[k] = PW'(push_n);
      push_n = push_n + CW'(pre_to_now_valid_i[k]);
    end
  end
  for (genvar i = 0; i < OUT_LANES; i++) begin : g_out
    assign now_to_next_valid_o[i] = CW'(i) < avail;
    assign to_next_obus[i*ENTRY_W +: ENTRY_W] = mem[head_ptr + PW'(i)];
  end
  always_ff @(posedge clk)
    if (push)
      for (int k = 0; k < IN_LANES; k++)
        if (pre_to_now_valid_i[k]) mem[tail_ptr + off[k]] <= pre_to_ibus[k*ENTRY_W +: ENTRY_W];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(push_n);
      head_ptr <= head_ptr + PW'(pop_n);
      count    <= count + (push ? push_n : '0) - pop_n;
    end
  end
endmodule
